// File: rtl/store_unit_if.sv
// Bus bundle for store_unit: instruction handshake, register-file read port
// and data-memory write port. The slave modport is the store unit itself.
interface store_unit_if #(
  parameter int word_size  = 32,
  parameter int reg_addr_w = 9,
  parameter int mem_addr_w = 16
);
  logic                  instr_valid;
  logic [word_size-1:0]  instruction;
  logic                  ready;
  logic [reg_addr_w-1:0] rf_addr;
  logic [word_size-1:0]  rf_data;
  logic [mem_addr_w-1:0] mem_addr;
  logic [word_size-1:0]  mem_wdata;
  logic                  mem_we;
  logic                  mem_ack;
  logic                  done;
  logic                  err;

  modport master (
    output instr_valid, instruction, rf_data, mem_ack,
    input  ready, rf_addr, mem_addr, mem_wdata, mem_we, done, err
  );

  modport slave (
    input  instr_valid, instruction, rf_data, mem_ack,
    output ready, rf_addr, mem_addr, mem_wdata, mem_we, done, err
  );
endinterface

// File: rtl/store_unit.sv
// STORE execution unit: reads rs from the register file, writes it to data memory at imm.
// Optional ack timeout enabled by defining STORE_ACK_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for a STORE instruction
// READ  | rf_addr=rs, capture register data and address
// WRITE | mem_we=1 until mem_ack (or timeout when enabled)
module store_unit #(
  parameter int              word_size      = 32,
  parameter int              opcode_size    = 5,
  parameter int              reg_addr_w     = 9,
  parameter int              mem_addr_w     = 16,
  parameter logic [4:0]      STORE_OPCODE   = 5'b10100,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  store_unit_if.slave bus
);

  localparam int IMM_W   = 9;
  localparam int OP_LSB  = word_size - opcode_size;
  localparam int RS_LSB  = OP_LSB - reg_addr_w;
  localparam int IMM_LSB = RS_LSB - IMM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [opcode_size-1:0] opcode;
  logic [reg_addr_w-1:0]  rs;
  logic [IMM_W-1:0]       imm;
  logic                   accept;
  logic                   timeout_hit;

  logic [reg_addr_w-1:0]  rf_addr_q, rf_addr_d;
  logic [IMM_W-1:0]       imm_q, imm_d;
  logic [mem_addr_w-1:0]  mem_addr_q, mem_addr_d;
  logic [word_size-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  assign opcode = bus.instruction[word_size-1 -: opcode_size];
  assign rs     = bus.instruction[RS_LSB +: reg_addr_w];
  assign imm    = bus.instruction[IMM_LSB +: IMM_W];
  assign accept = (state_q == IDLE) && bus.instr_valid && (opcode == STORE_OPCODE);

`ifdef STORE_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter holds the number of ack-less WRITE cycles already completed.
  assign timeout_hit = (state_q == WRITE) && !bus.mem_ack &&
                       (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == READ)
      tmo_cnt_d = '0;
    else if ((state_q == WRITE) && !bus.mem_ack && !timeout_hit)
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   if (bus.mem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_addr_d   = rf_addr_q;
    imm_d       = imm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rf_addr_d = rs;
          imm_d     = imm;
        end
      end
      READ: begin
        mem_wdata_d = bus.rf_data;
        mem_addr_d  = mem_addr_w'(imm_q);
        mem_we_d    = 1'b1;
      end
      WRITE: begin
        // An ack on the limit cycle still counts as a successful store.
        if (bus.mem_ack) begin
          mem_we_d = 1'b0;
          done_d   = 1'b1;
        end else if (timeout_hit) begin
          mem_we_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: mem_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_addr_q   <= '0;
      imm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rf_addr_q   <= rf_addr_d;
      imm_q       <= imm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.rf_addr   = rf_addr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: stimulus queues expected writes, a monitor
// checks each memory write and its completion pulse.
module tb_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_unit_if #(.word_size(32), .reg_addr_w(9), .mem_addr_w(16)) bus ();

  store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register-file model: combinational read.
  always_comb begin
    case (bus.rf_addr)
      9'd5:    bus.rf_data = 32'hDEADBEEF;
      9'd7:    bus.rf_data = 32'h00000042;
      default: bus.rf_data = {23'h5A5A5A, bus.rf_addr};
    endcase
  end

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          we_len;
    int          done_cyc;
    bit          is_err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ack_after = 1;
  int   we_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: ack on the ack_after-th cycle mem_we is high (0 = never).
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_we) we_run++;
      else            we_run = 0;
      bus.mem_ack = bus.mem_we && (ack_after != 0) && (we_run == ack_after);
    end
  end

  // Monitor
  initial begin
    int          we_len;
    logic [15:0] cap_addr;
    logic [31:0] cap_data;
    exp_t        e;
    we_len = 0;
    cap_addr = '0;
    cap_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_len = 0;
      end else begin
        if (bus.mem_we) begin
          we_len++;
          if (sb.size() == 0) begin
            chk("stray_mem_we", 32'(bus.mem_we), 32'd0);
          end else if (we_len == 1) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
            chk("mem_wdata", bus.mem_wdata, sb[0].data);
            cap_addr = bus.mem_addr;
            cap_data = bus.mem_wdata;
          end else begin
            chk("mem_addr_stable", 32'(bus.mem_addr), 32'(cap_addr));
            chk("mem_wdata_stable", bus.mem_wdata, cap_data);
          end
          chk("ready_while_we", 32'(bus.ready), 32'd0);
        end
        if (bus.done || bus.err) begin
          if (sb.size() == 0) begin
            chk("stray_done_err", {30'd0, bus.err, bus.done}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_pulse", 32'(bus.done), 32'(!e.is_err));
            chk("err_pulse", 32'(bus.err), 32'(e.is_err));
            chk("we_cycles", 32'(we_len), 32'(e.we_len));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("ready_on_done", 32'(bus.ready), 32'd1);
          end
          we_len = 0;
        end
      end
    end
  end

  // Present a STORE for one cycle; returns #1 after the accept edge.
  task automatic issue(input logic [31:0] instr, input logic [8:0] rs,
                       input logic [15:0] addr, input logic [31:0] data,
                       input int ack_n, input bit exp_err);
    exp_t e;
    bus.instruction = instr;
    bus.instr_valid = 1'b1;
    ack_after = ack_n;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0;
    chk("accept_ready", 32'(bus.ready), 32'd0);
    chk("rf_addr", 32'(bus.rf_addr), 32'(rs));
    e.addr     = addr;
    e.data     = data;
    e.is_err   = exp_err;
    e.we_len   = exp_err ? 16 : ack_n;
    e.done_cyc = cyc + 1 + e.we_len;
    sb.push_back(e);
  endtask

  task automatic wait_end(input string name, input int limit);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(bus.done || bus.err) && k < limit);
    if (!(bus.done || bus.err)) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_outputs", {bus.mem_we, bus.done, bus.err, 29'd0}, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic store, ack on first write cycle
    issue(32'hA0141800, 9'd5, 16'h000C, 32'hDEADBEEF, 1, 1'b0);
    wait_end("basic", 10);
    repeat (2) @(posedge clk);
    #1;

    // Delayed ack
    issue(32'hA0141800, 9'd5, 16'h000C, 32'hDEADBEEF, 4, 1'b0);
    wait_end("delayed", 12);
    @(posedge clk);
    #1;

    // Non-STORE opcode is ignored
    bus.instruction = 32'b10011000000000000000001000000000;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("load_ready", 32'(bus.ready), 32'd1);
      chk("load_no_we", 32'(bus.mem_we), 32'd0);
    end
    bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: second store offered on the done cycle
    issue(32'hA0141800, 9'd5, 16'h000C, 32'hDEADBEEF, 1, 1'b0);
    wait_end("b2b_first", 10);
    issue(32'hA01C0200, 9'd7, 16'h0001, 32'h00000042, 1, 1'b0);
    wait_end("b2b_second", 10);
    @(posedge clk);
    #1;

`ifdef STORE_ACK_TIMEOUT_EN
    // Ack never arrives: err after 16 write cycles
    issue(32'hA01C0200, 9'd7, 16'h0001, 32'h00000042, 0, 1'b1);
    wait_end("timeout", 30);
    @(posedge clk);
    #1;
    chk("tmo_ready_after", 32'(bus.ready), 32'd1);
    chk("tmo_we_after", 32'(bus.mem_we), 32'd0);
`else
    // Without the timeout the write waits for a late ack
    issue(32'hA01C0200, 9'd7, 16'h0001, 32'h00000042, 25, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("late_we_held", 32'(bus.mem_we), 32'd1);
    chk("late_no_err", 32'(bus.err), 32'd0);
    wait_end("late_ack", 20);
    @(posedge clk);
    #1;
`endif

    // Reset in the middle of a write
    issue(32'hA0141800, 9'd5, 16'h000C, 32'hDEADBEEF, 0, 1'b0);
    k = 0;
    while (!bus.mem_we && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("mid_we_high", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_flags", {30'd0, bus.done, bus.err}, 32'd0);
    chk("mid_rst_addr", {7'd0, bus.rf_addr, bus.mem_addr}, 32'd0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    ack_after = 1;
    @(posedge clk);
    #1;

    // Recovery after reset
    issue(32'hA01C0200, 9'd7, 16'h0001, 32'h00000042, 2, 1'b0);
    wait_end("recover", 10);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
